list_sum_engine: RTL
====================

# list_sum_engine

Parametrised linked-list summation engine: walks a singly linked list held in a synchronous-read word memory and accumulates the node values. Each node is a two-word record: value at `p`, next pointer at `p+1`. It replaces the hand-sequenced adder/latch/mux datapath plus external controller with one block that owns its FSM. It adds a start/done handshake, a configurable head address, overflow handling, loop protection and abort.

## Interface
Parameters:
- `DATA_W`, 32: width of node values, sum and memory data.
- `ADDR_W`, 8: memory address width; pointers are the low `ADDR_W` bits of the next word.
- `MAX_NODES`, 256: node-count limit; reaching it with a non-null next sets `err_loop`.
- `SATURATE`, 0: 0 = modulo-2^DATA_W sum; 1 = clamp at all-ones.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: begin a traversal; sampled only in IDLE.
- `abort` in 1: terminate a traversal in progress.
- `head_addr` in ADDR_W: first node address; 0 is the null pointer, meaning an empty list.
- `mem_rd` out 1: memory read strobe (combinational).
- `mem_addr` out ADDR_W: memory read address (combinational).
- `mem_rdata` in DATA_W: read data, valid the cycle after `mem_rd`.
- `busy` out 1: high in VAL and NXT.
- `done` out 1: one-cycle pulse at the end of every traversal.
- `sum` out DATA_W: accumulated sum.
- `node_count` out $clog2(MAX_NODES+1): nodes visited.
- `overflow` out 1: sticky; a carry-out occurred in this traversal.
- `err_loop` out 1: the traversal was cut at `MAX_NODES`.
- `aborted` out 1: the traversal ended by `abort`.

## Operation
- Reset (`rst`=0, async) sets:
  - state IDLE;
  - `sum`, `node_count`, `overflow`, `err_loop`, `aborted`, `done`, `busy` all 0;
  - `mem_rd` 0.
- IDLE, `start`=1:
  - Clear `sum`, `node_count` and all flags.
  - If `head_addr`==0, go to DONE.
  - Otherwise `mem_rd`=1, `mem_addr`=`head_addr`, `ptr`<=`head_addr`, go to VAL.
- VAL: `mem_rdata` holds the node value.
  - Accumulate the value into `sum`.
  - Drive `mem_rd`=1, `mem_addr`=`ptr`+1 (mod 2^ADDR_W).
  - Go to NXT.
- NXT: `mem_rdata` holds the next pointer; let `nxt` = its low ADDR_W bits.
  - `node_count`++.
  - If `nxt`==0, go to DONE.
  - Else if `node_count`+1==`MAX_NODES`, set `err_loop` and go to DONE.
  - Else drive `mem_rd`=1, `mem_addr`=`nxt`, `ptr`<=`nxt`, go to VAL.
  - Upper pointer bits above ADDR_W are ignored.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Results hold in IDLE until the next accepted `start`.
- Arithmetic: unsigned, DATA_W+1-bit add.
  - A carry sets `overflow` (sticky) in both modes.
  - `SATURATE`=1: on carry, `sum` becomes all-ones and stays there for the rest of the traversal.
  - `SATURATE`=0: `sum` wraps.
- `abort` in VAL or NXT:
  - Go to DONE next cycle and set `aborted`.
  - The current VAL accumulate and NXT count still complete that cycle; no further read is issued.
- `start` while busy or in DONE is ignored.
- `abort` in IDLE or DONE is ignored.

## Timing
- Accepted `start` at cycle 0, list of N≥1 nodes: VAL at cycles 1,3,…,2N-1; NXT at 2,4,…,2N; `done` at cycle 2N+1.
- Empty list: `done` at cycle 1, `sum`=0, no memory read.
- `busy` is high from cycle 1 through cycle 2N.
- `sum` and `node_count` are final when `done` is high and remain stable afterwards.
- Memory latency is fixed at one cycle; no wait-state support.
- `mem_addr` is don't-care when `mem_rd`=0. It is held at 0 to ease waveform checking.
- Reset asserted mid-traversal returns to IDLE immediately. No `done` pulse is produced.
- Back-to-back traversals: `start` in the IDLE cycle right after DONE is accepted. Minimum spacing is 2N+2 cycles.

## Structure
- Package `list_sum_pkg`:
  - state enum IDLE/VAL/NXT/DONE;
  - `NULL_PTR`=0;
  - `VAL_OFS`=0, `NXT_OFS`=1.
- Sub-module `sat_accumulator` (parameters `DATA_W`, `SATURATE`): clear, add-enable, sum register and sticky overflow. The FSM and pointer/count registers live in `list_sum_engine`.

## Test plan
- Three nodes at 4→10→20, values 5, 7, 9, next@21=0, `start` with head=4 -> `done` at cycle 7, `sum`=21, `node_count`=3, all flags 0.
- `head_addr`=0 -> `done` at cycle 1, `sum`=0, `mem_rd` never asserted.
- DATA_W=8, values 200 and 100:
  - `SATURATE`=0 -> `sum`=44, `overflow`=1;
  - `SATURATE`=1 -> `sum`=255, `overflow`=1.
- Self-loop node at 6 (next@7=6), MAX_NODES=4 -> `done` at cycle 9, `node_count`=4, `err_loop`=1.
- Five-node list, `abort` in cycle 3 (VAL of node 2) -> `done` at cycle 4, `aborted`=1, `sum`=v1+v2, `node_count`=1.
- `rst` pulled low at cycle 2 of a traversal -> all outputs 0 asynchronously; a fresh `start` then completes normally with the correct sum.

Source files
------------

// File: rtl/list_sum_pkg.sv
// rtl/list_sum_pkg.sv - state encoding and node layout shared by the list summation engine
package list_sum_pkg;

  typedef enum logic [1:0] {
    IDLE,
    VAL,
    NXT,
    DONE
  } state_t;

  localparam int NULL_PTR = 0;
  localparam int VAL_OFS  = 0;
  localparam int NXT_OFS  = 1;

endpackage

// File: rtl/sat_accumulator.sv
// rtl/sat_accumulator.sv - unsigned accumulator with sticky carry flag and optional clamp at all-ones
module sat_accumulator #(
  parameter int DATA_W   = 32,
  parameter int SATURATE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              add_en,
  input  logic [DATA_W-1:0] addend,
  output logic [DATA_W-1:0] sum,
  output logic              overflow
);

  logic [DATA_W:0] wide;

  assign wide = {1'b0, sum} + {1'b0, addend};

  // Once clamped, any further nonzero addend carries again, so the clamp holds by itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum      <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      sum      <= '0;
      overflow <= 1'b0;
    end else if (add_en) begin
      if (wide[DATA_W]) begin
        overflow <= 1'b1;
        sum      <= (SATURATE != 0) ? '1 : wide[DATA_W-1:0];
      end else begin
        sum <= wide[DATA_W-1:0];
      end
    end
  end

endmodule

// File: rtl/list_sum_engine.sv
// rtl/list_sum_engine.sv - walks a linked list in synchronous-read memory and sums the node values
module list_sum_engine
  import list_sum_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 8,
  parameter int MAX_NODES = 256,
  parameter int SATURATE  = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           abort,
  input  logic [ADDR_W-1:0]              head_addr,
  output logic                           mem_rd,
  output logic [ADDR_W-1:0]              mem_addr,
  input  logic [DATA_W-1:0]              mem_rdata,
  output logic                           busy,
  output logic                           done,
  output logic [DATA_W-1:0]              sum,
  output logic [$clog2(MAX_NODES+1)-1:0] node_count,
  output logic                           overflow,
  output logic                           err_loop,
  output logic                           aborted
);

  localparam int CNT_W = $clog2(MAX_NODES + 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic [ADDR_W-1:0] nxt;
  logic              start_ok;
  logic              at_limit;
  logic              nxt_null;

  assign nxt      = mem_rdata[ADDR_W-1:0];
  assign nxt_null = (nxt == ADDR_W'(NULL_PTR));
  assign start_ok = (state == IDLE) && start;
  assign at_limit = ((node_count + CNT_W'(1)) == CNT_W'(MAX_NODES));
  assign busy     = (state == VAL) || (state == NXT);
  assign done     = (state == DONE);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    mem_rd    = 1'b0;
    mem_addr  = '0;
    case (state)
      IDLE: begin
        if (start) begin
          if (head_addr == ADDR_W'(NULL_PTR)) begin
            state_nxt = DONE;
          end else begin
            mem_rd    = 1'b1;
            mem_addr  = head_addr + ADDR_W'(VAL_OFS);
            ptr_nxt   = head_addr;
            state_nxt = VAL;
          end
        end
      end
      VAL: begin
        if (abort) begin
          state_nxt = DONE;
        end else begin
          mem_rd    = 1'b1;
          mem_addr  = ptr + ADDR_W'(NXT_OFS);
          state_nxt = NXT;
        end
      end
      NXT: begin
        if (abort || nxt_null || at_limit) begin
          state_nxt = DONE;
        end else begin
          mem_rd    = 1'b1;
          mem_addr  = nxt + ADDR_W'(VAL_OFS);
          ptr_nxt   = nxt;
          state_nxt = VAL;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Abort wins over the loop limit when both land on the same NXT cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ptr        <= '0;
      node_count <= '0;
      err_loop   <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      if (start_ok) begin
        node_count <= '0;
        err_loop   <= 1'b0;
        aborted    <= 1'b0;
      end else if (state == NXT) begin
        node_count <= node_count + CNT_W'(1);
        if (abort)
          aborted <= 1'b1;
        else if (!nxt_null && at_limit)
          err_loop <= 1'b1;
      end else if ((state == VAL) && abort) begin
        aborted <= 1'b1;
      end
    end
  end

  sat_accumulator #(
    .DATA_W   (DATA_W),
    .SATURATE (SATURATE)
  ) u_acc (
    .clk      (clk),
    .rst      (rst),
    .clear    (start_ok),
    .add_en   (state == VAL),
    .addend   (mem_rdata),
    .sum      (sum),
    .overflow (overflow)
  );

endmodule
